// File: rtl/ycc_block_buffer_if.sv
// Stream bundle between the colour converter, the block buffer and the block-order consumer.
// The slave view belongs to the buffer; the master view belongs to whatever drives and sinks it.
interface ycc_block_buffer_if;
  logic [7:0]        y;
  logic [7:0]        cb;
  logic [7:0]        cr;
  logic              vld_i;
  logic              sof_i;
  logic signed [7:0] y_o;
  logic signed [7:0] cb_o;
  logic signed [7:0] cr_o;
  logic              vld_o;
  logic              rdy_i;
  logic              blk_last_o;
  logic              band_last_o;
  logic              ovf_o;

  modport slave (
    input  y, cb, cr, vld_i, sof_i, rdy_i,
    output y_o, cb_o, cr_o, vld_o, blk_last_o, band_last_o, ovf_o
  );

  modport master (
    output y, cb, cr, vld_i, sof_i, rdy_i,
    input  y_o, cb_o, cr_o, vld_o, blk_last_o, band_last_o, ovf_o
  );
endinterface

// File: rtl/ycc_block_buffer.sv
// Double-banked band buffer: takes raster-order YCbCr pixels and replays each 8-row band
// as level-shifted 8x8 blocks, one bank filling while the other drains.
module ycc_block_buffer #(
  parameter int IMG_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  ycc_block_buffer_if.slave bus
);

  localparam int NBLK  = IMG_W / 8;
  localparam int CW    = $clog2(IMG_W);
  localparam int BW    = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int DEPTH = 16 * IMG_W;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(NBLK - 1);

  // Flat storage: bank-major, then row, then column.
  function automatic logic [AW-1:0] addr_of(logic bank, logic [2:0] row, int col);
    return AW'((int'(bank) * 8 + int'(row)) * IMG_W + col);
  endfunction

  logic [23:0]   mem_q [DEPTH];

  logic          wb_q, wb_d;
  logic [2:0]    wrow_q, wrow_d;
  logic [CW-1:0] wcol_q, wcol_d;
  logic [1:0]    full_q, full_d;
  logic          ovf_q, ovf_d;

  logic          rb_q, rb_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [2:0]    r_q, r_d;
  logic [2:0]    c_q, c_d;
  logic          vld_q, vld_d;
  logic [7:0]    y_q, y_d, cb_q, cb_d, cr_q, cr_d;
  logic          blk_last_q, blk_last_d;
  logic          band_last_q, band_last_d;

  logic          wr_en, wr_band_end;
  logic [2:0]    wr_row;
  logic [CW-1:0] wr_col;
  logic [AW-1:0] wr_addr;

  logic          rd_load, rd_blk_last, rd_band_last;
  logic [23:0]   rd_pix;

  // Start-of-frame forces the pixel to the band origin, dropping any partial band.
  assign wr_row      = bus.sof_i ? 3'd0 : wrow_q;
  assign wr_col      = bus.sof_i ? '0   : wcol_q;
  assign wr_en       = bus.vld_i && !full_q[wb_q];
  assign wr_band_end = wr_en && (wr_row == 3'd7) && (wr_col == COL_MAX);
  assign wr_addr     = addr_of(wb_q, wr_row, int'(wr_col));

  // Writes only touch a non-full bank and reads only a full one, so they never collide.
  assign rd_load      = (!vld_q || bus.rdy_i) && full_q[rb_q];
  assign rd_blk_last  = (r_q == 3'd7) && (c_q == 3'd7);
  assign rd_band_last = rd_blk_last && (blk_q == BLK_MAX);
  assign rd_pix       = mem_q[addr_of(rb_q, r_q, int'(blk_q) * 8 + int'(c_q))];

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    wb_d        = wb_q;
    wrow_d      = wrow_q;
    wcol_d      = wcol_q;
    full_d      = full_q;
    ovf_d       = ovf_q;
    rb_d        = rb_q;
    blk_d       = blk_q;
    r_d         = r_q;
    c_d         = c_q;
    vld_d       = vld_q;
    y_d         = y_q;
    cb_d        = cb_q;
    cr_d        = cr_q;
    blk_last_d  = blk_last_q;
    band_last_d = band_last_q;

    if (wr_en) begin
      if (wr_band_end) begin
        wb_d           = ~wb_q;
        wrow_d         = 3'd0;
        wcol_d         = '0;
        full_d[wb_q]   = 1'b1;
      end else if (wr_col == COL_MAX) begin
        wcol_d = '0;
        wrow_d = wr_row + 3'd1;
      end else begin
        wcol_d = wr_col + 1'b1;
        wrow_d = wr_row;
      end
    end
    if (bus.vld_i && full_q[wb_q]) ovf_d = 1'b1;

    if (rd_load) begin
      vld_d       = 1'b1;
      // Subtracting 128 from an unsigned byte is just an MSB flip in two's complement.
      y_d         = {~rd_pix[23], rd_pix[22:16]};
      cb_d        = {~rd_pix[15], rd_pix[14:8]};
      cr_d        = {~rd_pix[7],  rd_pix[6:0]};
      blk_last_d  = rd_blk_last;
      band_last_d = rd_band_last;
      c_d         = c_q + 3'd1;
      if (c_q == 3'd7) r_d = r_q + 3'd1;
      if (rd_blk_last) blk_d = rd_band_last ? '0 : blk_q + 1'b1;
      if (rd_band_last) begin
        rb_d         = ~rb_q;
        full_d[rb_q] = 1'b0;
      end
    end else if (bus.rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      wb_q        <= 1'b0;
      wrow_q      <= 3'd0;
      wcol_q      <= '0;
      full_q      <= 2'b00;
      ovf_q       <= 1'b0;
      rb_q        <= 1'b0;
      blk_q       <= '0;
      r_q         <= 3'd0;
      c_q         <= 3'd0;
      vld_q       <= 1'b0;
      y_q         <= 8'd0;
      cb_q        <= 8'd0;
      cr_q        <= 8'd0;
      blk_last_q  <= 1'b0;
      band_last_q <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      wrow_q      <= wrow_d;
      wcol_q      <= wcol_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      rb_q        <= rb_d;
      blk_q       <= blk_d;
      r_q         <= r_d;
      c_q         <= c_d;
      vld_q       <= vld_d;
      y_q         <= y_d;
      cb_q        <= cb_d;
      cr_q        <= cr_d;
      blk_last_q  <= blk_last_d;
      band_last_q <= band_last_d;
    end
  end

  // NOTE: the pixel array has no reset; cleared full flags make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= {bus.y, bus.cb, bus.cr};
  end

  assign bus.y_o         = y_q;
  assign bus.cb_o        = cb_q;
  assign bus.cr_o        = cr_q;
  assign bus.vld_o       = vld_q;
  assign bus.blk_last_o  = blk_last_q;
  assign bus.band_last_o = band_last_q;
  assign bus.ovf_o       = ovf_q;

endmodule

// File: tb/tb_ycc_block_buffer.sv
// Scoreboard bench for ycc_block_buffer at IMG_W=16: stimulus pushes expected block-order
// samples, an independent monitor pops and compares on every output transfer.
module tb_ycc_block_buffer;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       bl;
    logic       bdl;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  ycc_block_buffer_if bus ();

  ycc_block_buffer #(.IMG_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   first_xfer_cyc = 0;
  int   last_xfer_cyc = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(int p, int g);
    logic [7:0] yy, bb, rr;
    yy = 8'(g + p);
    bb = 8'(g * 3 + p * 7 + 1);
    rr = 8'(~(g ^ (p * 29)));
    return {yy, bb, rr};
  endfunction

  // Expected block-major replay of one band whose pixel n (raster index) is pix(p, g0+n).
  task automatic push_band(int p, int g0);
    for (int k = 0; k < 128; k++) begin
      int b, r, c, n;
      logic [23:0] px;
      exp_t e;
      b  = k / 64;
      r  = (k % 64) / 8;
      c  = k % 8;
      n  = r * 16 + b * 8 + c;
      px = pix(p, g0 + n);
      e.y   = px[23:16] ^ 8'h80;
      e.cb  = px[15:8]  ^ 8'h80;
      e.cr  = px[7:0]   ^ 8'h80;
      e.bl  = ((k % 64) == 63);
      e.bdl = (k == 127);
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && bus.vld_o && bus.rdy_i) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_output: got y_o=%h with no sample expected", bus.y_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("sample%0d", xfer_cnt),
              64'({bus.y_o, bus.cb_o, bus.cr_o, bus.blk_last_o, bus.band_last_o}), 64'(e));
      end
      if (xfer_cnt == 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      xfer_cnt++;
    end
  end

  task automatic drive_pix(int p, int g, bit sof);
    logic [23:0] px;
    px = pix(p, g);
    bus.y     = px[23:16];
    bus.cb    = px[15:8];
    bus.cr    = px[7:0];
    bus.vld_i = 1'b1;
    bus.sof_i = sof;
  endtask

  task automatic send(int p, int g0, int cnt, bit sof_first);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      if (i == 0) start_cyc = cyc;
      drive_pix(p, g0 + i, sof_first && (i == 0));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.vld_i = 1'b0;
    bus.sof_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    bus.y = 8'($urandom); bus.cb = 8'($urandom); bus.cr = 8'($urandom);
    bus.vld_i = 1'($urandom); bus.sof_i = 1'($urandom); bus.rdy_i = 1'($urandom);
    #1;
    check("reset_outputs_zero",
          64'({bus.y_o, bus.cb_o, bus.cr_o, bus.vld_o, bus.blk_last_o, bus.band_last_o, bus.ovf_o}), 64'd0);
    repeat (3) @(negedge clk);
    bus.vld_i = 1'b0;
    bus.sof_i = 1'b0;
    q.delete();
    xfer_cnt = 0;
    rstn = 1'b1;
  endtask

  task automatic drain(string name);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_queue_empty"}, 64'(q.size()), 64'd0);
    repeat (6) @(negedge clk);
    check({name, "_vld_low_after"}, 64'(bus.vld_o), 64'd0);
  endtask

  task automatic wait_xfers(int target, string name);
    int n = 0;
    while (xfer_cnt < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_reached"}, 64'(xfer_cnt >= target), 64'd1);
  endtask

  initial begin
    bus.y = 8'd0; bus.cb = 8'd0; bus.cr = 8'd0;
    bus.vld_i = 1'b0; bus.sof_i = 1'b0; bus.rdy_i = 1'b0;

    // Reset state and idle behaviour.
    begin
      logic seen;
      do_reset();
      bus.rdy_i = 1'b1;
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        seen = seen | bus.vld_o;
      end
      check("idle_no_output", 64'(seen), 64'd0);
    end

    // Two back-to-back bands with y = raster index: latency, block order, full-rate across bands.
    do_reset();
    bus.rdy_i = 1'b1;
    push_band(0, 0);
    push_band(0, 128);
    send(0, 0, 256, 1'b0);
    idle();
    drain("basic");
    check("basic_first_latency", 64'(first_xfer_cyc - start_cyc), 64'd129);
    check("basic_throughput", 64'(last_xfer_cyc - first_xfer_cyc), 64'd255);
    check("basic_ovf_clear", 64'(bus.ovf_o), 64'd0);

    // Back-pressure at sample 20: the held sample must stay the next expected one.
    do_reset();
    bus.rdy_i = 1'b1;
    push_band(4, 0);
    send(4, 0, 128, 1'b0);
    idle();
    wait_xfers(20, "bp_wait");
    bus.rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            64'({bus.vld_o, bus.y_o, bus.cb_o, bus.cr_o, bus.blk_last_o, bus.band_last_o}),
            64'({1'b1, q[0].y, q[0].cb, q[0].cr, q[0].bl, q[0].bdl}));
    end
    @(posedge clk);
    #1;
    bus.rdy_i = 1'b1;
    drain("bp");
    check("bp_total", 64'(xfer_cnt), 64'd128);

    // Overflow: both banks fill under a stalled sink, pixel 257 onward is dropped.
    do_reset();
    bus.rdy_i = 1'b0;
    push_band(1, 0);
    push_band(1, 128);
    send(1, 0, 256, 1'b0);
    @(negedge clk);
    check("ovf_before_257", 64'(bus.ovf_o), 64'd0);
    drive_pix(1, 256, 1'b0);
    @(negedge clk);
    check("ovf_after_257", 64'(bus.ovf_o), 64'd1);
    drive_pix(1, 257, 1'b0);
    send(1, 258, 126, 1'b0);
    idle();
    @(posedge clk);
    #1;
    bus.rdy_i = 1'b1;
    drain("ovf");
    check("ovf_total", 64'(xfer_cnt), 64'd256);
    check("ovf_sticky", 64'(bus.ovf_o), 64'd1);

    // Frame restart: a 50-pixel partial band is abandoned by sof_i.
    do_reset();
    bus.rdy_i = 1'b1;
    push_band(3, 0);
    send(2, 0, 50, 1'b0);
    send(3, 0, 128, 1'b1);
    idle();
    drain("sof");
    check("sof_total", 64'(xfer_cnt), 64'd128);
    check("sof_ovf_clear", 64'(bus.ovf_o), 64'd0);

    // Mid-stream reset while a band is draining, then a fresh band.
    do_reset();
    bus.rdy_i = 1'b1;
    push_band(5, 0);
    send(5, 0, 128, 1'b0);
    idle();
    wait_xfers(30, "mid_wait");
    #1;
    rstn = 1'b0;
    #1;
    check("mid_reset_async",
          64'({bus.y_o, bus.cb_o, bus.cr_o, bus.vld_o, bus.blk_last_o, bus.band_last_o, bus.ovf_o}), 64'd0);
    q.delete();
    @(negedge clk);
    xfer_cnt = 0;
    rstn = 1'b1;
    push_band(6, 0);
    send(6, 0, 128, 1'b0);
    idle();
    drain("mid");
    check("mid_total", 64'(xfer_cnt), 64'd128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
